// File: rtl/rr_mux_arbiter.sv
// Registered CHANNELS:1 multiplexer with per-channel valid/ready handshakes.
// Round-robin or direct-select arbitration feeds a one-entry output register.
module rr_mux_arbiter #(
    parameter int N        = 1,
    parameter int CHANNELS = 32,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS*N-1:0] in_data,
    input  logic [CHANNELS-1:0]   in_valid,
    output logic [CHANNELS-1:0]   in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      select,
    output logic [N-1:0]          out_data,
    output logic [SEL_W-1:0]      out_select,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state, state_next;
    logic [SEL_W-1:0] last_grant;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_found;
    logic             load_en;
    logic             accept;
    logic [N-1:0]     grant_word;
    int               scan_idx;

    // Descending scan so the channel closest after last_grant is the final winner
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        if (mode) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (SEL_W'(i) == select && in_valid[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = SEL_W'(i);
                end
            end
        end else begin
            for (int k = CHANNELS; k >= 1; k--) begin
                scan_idx = int'(last_grant) + k;
                if (scan_idx >= CHANNELS) begin
                    scan_idx = scan_idx - CHANNELS;
                end
                if (in_valid[scan_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = SEL_W'(scan_idx);
                end
            end
        end
    end

    always_comb begin
        out_valid  = (state == FULL);
        load_en    = (state == EMPTY) || out_ready;
        accept     = grant_found && load_en && !rst;
        grant_word = in_data[grant_idx*N +: N];
        in_ready   = '0;
        if (accept) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // A drain with a simultaneous load stays FULL, giving one word per cycle
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = FULL;
        end else if (state == FULL && out_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_select <= '0;
            last_grant <= SEL_W'(CHANNELS - 1);
        end else begin
            state <= state_next;
            if (accept) begin
                out_data   <= grant_word;
                out_select <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

endmodule
